// File: rtl/buffer_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// buffer_ptr_ctrl
//   Pointer/occupancy controller for the column circular buffer. Owns the
//   write pointer, the read pointer and the occupancy count. Accepts one column
//   write per cycle, reports when PAR_READ consecutive columns are readable and
//   releases STRIDE columns per accepted pop. Both pointers wrap modulo COLUMNS
//   (COLUMNS need not be a power of two).
//
//   Optional feature: define BUF_PTR_ERR_FLAGS_EN to add sticky overflow and
//   underflow flags (ovf_err / unf_err), cleared only by rst or clr.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset (priority over clr)
//   clr       in   synchronous flush; wen/ren in the same cycle are ignored
//   wen       in   write request for one column
//   ren       in   pop request (consume STRIDE columns)
//   waddr     out  column address for the current write (= write pointer)
//   we_acc    out  write accepted this cycle; buffer write enable
//   read_ptr  out  base read column for the parallel address generator
//   rd_valid  out  count >= PAR_READ
//   pop_acc   out  pop accepted this cycle
//   full      out  count == COLUMNS
//   empty     out  count == 0
//   count     out  current occupancy
//   ovf_err   out  sticky: write requested while full   (BUF_PTR_ERR_FLAGS_EN)
//   unf_err   out  sticky: pop requested while !rd_valid (BUF_PTR_ERR_FLAGS_EN)
// -----------------------------------------------------------------------------
module buffer_ptr_ctrl #(
  parameter int COLUMNS  = 32,
  parameter int PAR_READ = 4,
  parameter int STRIDE   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       wen,
  input  logic                       ren,
  output logic [$clog2(COLUMNS)-1:0] waddr,
  output logic                       we_acc,
  output logic [$clog2(COLUMNS)-1:0] read_ptr,
  output logic                       rd_valid,
  output logic                       pop_acc,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(COLUMNS):0]   count
`ifdef BUF_PTR_ERR_FLAGS_EN
  ,
  output logic                       ovf_err,
  output logic                       unf_err
`endif
);

  localparam int PW = $clog2(COLUMNS);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] COLS_C   = CW'(COLUMNS);
  localparam logic [CW-1:0] PAR_C    = CW'(PAR_READ);
  localparam logic [CW-1:0] STRIDE_C = CW'(STRIDE);
  localparam logic [PW-1:0] LAST_COL = PW'(COLUMNS - 1);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q,  cnt_d;
  logic [CW-1:0] rsum;

  // Status is decoded purely from registered state.
  assign full     = (cnt_q == COLS_C);
  assign empty    = (cnt_q == '0);
  assign rd_valid = (cnt_q >= PAR_C);
  assign waddr    = wptr_q;
  assign read_ptr = rptr_q;
  assign count    = cnt_q;

  // Acceptance uses only the registered full/rd_valid, so a pop in the same
  // cycle never frees room for a write (no bypass). A flush or reset cycle
  // must not write the buffer, hence the extra qualification.
  assign we_acc  = wen && !full     && !clr && !rst;
  assign pop_acc = ren && rd_valid  && !clr && !rst;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise a latch would be inferred.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    rsum   = {1'b0, rptr_q} + STRIDE_C;

    if (we_acc) begin
      wptr_d = (wptr_q == LAST_COL) ? '0 : wptr_q + PW'(1);
    end

    // Sum is one bit wider than the pointer, so a single conditional
    // subtract wraps correctly for any COLUMNS, power of two or not.
    if (pop_acc) begin
      rptr_d = (rsum >= COLS_C) ? PW'(rsum - COLS_C) : PW'(rsum);
    end

    // Cannot underflow: a pop needs count >= PAR_READ >= STRIDE.
    cnt_d = cnt_q + CW'(we_acc) - (pop_acc ? STRIDE_C : '0);
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef BUF_PTR_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // Sticky: once set, only rst/clr clears them.
  always_comb begin
    ovf_d = ovf_q | (wen && full);
    unf_d = unf_q | (ren && !rd_valid);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ovf_err = ovf_q;
  assign unf_err = unf_q;
`endif

endmodule

// File: tb/tb_buffer_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_buffer_ptr_ctrl
//   Two instances: dut 0 (COLUMNS=32, PAR_READ=4, STRIDE=1) and dut 1
//   (COLUMNS=24, PAR_READ=4, STRIDE=4). A reference model tracks pointers and
//   occupancy; expected write addresses and post-pop read pointers are queued
//   when stimulus is driven and popped when the DUT produces them.
// -----------------------------------------------------------------------------
module tb_buffer_ptr_ctrl;

  localparam int PW = 5;
  localparam int CW = 6;

  localparam int COLS [2] = '{32, 24};
  localparam int PARS [2] = '{4, 4};
  localparam int STRS [2] = '{1, 4};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]         rst, clr, wen, ren;
  logic [1:0][PW-1:0] waddr_v, read_ptr_v;
  logic [1:0][CW-1:0] count_v;
  logic [1:0]         we_acc, pop_acc, rd_valid, full, empty;
`ifdef BUF_PTR_ERR_FLAGS_EN
  logic [1:0]         ovf_v, unf_v;
`endif

  buffer_ptr_ctrl #(.COLUMNS(32), .PAR_READ(4), .STRIDE(1)) dut0 (
    .clk(clk), .rst(rst[0]), .clr(clr[0]), .wen(wen[0]), .ren(ren[0]),
    .waddr(waddr_v[0]), .we_acc(we_acc[0]), .read_ptr(read_ptr_v[0]),
    .rd_valid(rd_valid[0]), .pop_acc(pop_acc[0]), .full(full[0]),
    .empty(empty[0]), .count(count_v[0])
`ifdef BUF_PTR_ERR_FLAGS_EN
    , .ovf_err(ovf_v[0]), .unf_err(unf_v[0])
`endif
  );

  buffer_ptr_ctrl #(.COLUMNS(24), .PAR_READ(4), .STRIDE(4)) dut1 (
    .clk(clk), .rst(rst[1]), .clr(clr[1]), .wen(wen[1]), .ren(ren[1]),
    .waddr(waddr_v[1]), .we_acc(we_acc[1]), .read_ptr(read_ptr_v[1]),
    .rd_valid(rd_valid[1]), .pop_acc(pop_acc[1]), .full(full[1]),
    .empty(empty[1]), .count(count_v[1])
`ifdef BUF_PTR_ERR_FLAGS_EN
    , .ovf_err(ovf_v[1]), .unf_err(unf_v[1])
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model
  int m_wp [2];
  int m_rp [2];
  int m_cnt[2];
  bit m_ovf[2];
  bit m_unf[2];

  // Scoreboard queues
  int wq[$];
  int rq[$];

  task automatic do_reset(input int d);
    @(negedge clk);
    rst[d] = 1'b1; clr[d] = 1'b0; wen[d] = 1'b0; ren[d] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst[d] = 1'b0;
    m_wp[d] = 0; m_rp[d] = 0; m_cnt[d] = 0; m_ovf[d] = 1'b0; m_unf[d] = 1'b0;
  endtask

  // One clock of stimulus on dut d with scoreboard and model checks.
  task automatic cyc(input int d, input bit w, input bit r, input bit c);
    bit exp_we, exp_pop;
    int exp_v;
    @(negedge clk);
    wen[d] = w; ren[d] = r; clr[d] = c;
    #1;
    exp_we  = w && !c && (m_cnt[d] != COLS[d]);
    exp_pop = r && !c && (m_cnt[d] >= PARS[d]);
    checks++;
    if (we_acc[d] !== exp_we) begin
      failures++;
      $display("FAIL we_acc dut%0d: got %b expected %b", d, we_acc[d], exp_we);
    end
    checks++;
    if (pop_acc[d] !== exp_pop) begin
      failures++;
      $display("FAIL pop_acc dut%0d: got %b expected %b", d, pop_acc[d], exp_pop);
    end
    if (exp_we)  wq.push_back(m_wp[d]);
    if (exp_pop) rq.push_back((m_rp[d] + STRS[d]) % COLS[d]);
    if (we_acc[d] === 1'b1) begin
      checks++;
      if (wq.size() == 0) begin
        failures++;
        $display("FAIL waddr dut%0d: got write at %0d expected no write", d, waddr_v[d]);
      end else begin
        exp_v = wq.pop_front();
        if (int'(waddr_v[d]) !== exp_v) begin
          failures++;
          $display("FAIL waddr dut%0d: got %0d expected %0d", d, waddr_v[d], exp_v);
        end
      end
    end
    // Model update for this edge
    if (c) begin
      m_ovf[d] = 1'b0; m_unf[d] = 1'b0;
      m_wp[d] = 0; m_rp[d] = 0; m_cnt[d] = 0;
    end else begin
      if (w && m_cnt[d] == COLS[d]) m_ovf[d] = 1'b1;
      if (r && m_cnt[d] <  PARS[d]) m_unf[d] = 1'b1;
      if (exp_we)  begin m_wp[d] = (m_wp[d] + 1) % COLS[d]; m_cnt[d]++; end
      if (exp_pop) begin m_rp[d] = (m_rp[d] + STRS[d]) % COLS[d]; m_cnt[d] -= STRS[d]; end
    end
    @(posedge clk);
    #1;
    if (rq.size() > 0) begin
      exp_v = rq.pop_front();
      checks++;
      if (int'(read_ptr_v[d]) !== exp_v) begin
        failures++;
        $display("FAIL read_ptr_after_pop dut%0d: got %0d expected %0d", d, read_ptr_v[d], exp_v);
      end
    end
    checks++;
    if (int'(count_v[d]) !== m_cnt[d] || int'(waddr_v[d]) !== m_wp[d] ||
        int'(read_ptr_v[d]) !== m_rp[d]) begin
      failures++;
      $display("FAIL state dut%0d: got cnt=%0d wp=%0d rp=%0d expected cnt=%0d wp=%0d rp=%0d",
               d, count_v[d], waddr_v[d], read_ptr_v[d], m_cnt[d], m_wp[d], m_rp[d]);
    end
    checks++;
    if (full[d] !== (m_cnt[d] == COLS[d]) || empty[d] !== (m_cnt[d] == 0) ||
        rd_valid[d] !== (m_cnt[d] >= PARS[d])) begin
      failures++;
      $display("FAIL status dut%0d: got full=%b empty=%b rd_valid=%b for cnt=%0d",
               d, full[d], empty[d], rd_valid[d], m_cnt[d]);
    end
`ifdef BUF_PTR_ERR_FLAGS_EN
    checks++;
    if (ovf_v[d] !== m_ovf[d] || unf_v[d] !== m_unf[d]) begin
      failures++;
      $display("FAIL err_flags dut%0d: got ovf=%b unf=%b expected ovf=%b unf=%b",
               d, ovf_v[d], unf_v[d], m_ovf[d], m_unf[d]);
    end
`endif
  endtask

  task automatic test_reset();
    do_reset(0);
    do_reset(1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (count_v[d] !== '0 || empty[d] !== 1'b1 || full[d] !== 1'b0 ||
          rd_valid[d] !== 1'b0 || read_ptr_v[d] !== '0 || waddr_v[d] !== '0) begin
        failures++;
        $display("FAIL reset dut%0d: got cnt=%0d empty=%b full=%b rdv=%b rp=%0d wp=%0d expected 0/1/0/0/0/0",
                 d, count_v[d], empty[d], full[d], rd_valid[d], read_ptr_v[d], waddr_v[d]);
      end
    end
  endtask

  task automatic test_write();
    for (int i = 0; i < 4; i++) cyc(0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (count_v[0] !== 6'd4 || rd_valid[0] !== 1'b1 || read_ptr_v[0] !== 5'd0) begin
      failures++;
      $display("FAIL four_writes: got cnt=%0d rdv=%b rp=%0d expected 4/1/0",
               count_v[0], rd_valid[0], read_ptr_v[0]);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 28; i++) cyc(0, 1'b1, 1'b0, 1'b0);
    cyc(0, 1'b1, 1'b0, 1'b0);  // 33rd write, refused
    checks++;
    if (full[0] !== 1'b1 || count_v[0] !== 6'd32 || waddr_v[0] !== 5'd0) begin
      failures++;
      $display("FAIL overfill: got full=%b cnt=%0d wp=%0d expected 1/32/0",
               full[0], count_v[0], waddr_v[0]);
    end
`ifdef BUF_PTR_ERR_FLAGS_EN
    checks++;
    if (ovf_v[0] !== 1'b1) begin
      failures++;
      $display("FAIL ovf_err: got %b expected 1", ovf_v[0]);
    end
`endif
  endtask

  task automatic test_full_wr_pop();
    cyc(0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (count_v[0] !== 6'd31 || read_ptr_v[0] !== 5'd1) begin
      failures++;
      $display("FAIL full_wr_pop: got cnt=%0d rp=%0d expected 31/1", count_v[0], read_ptr_v[0]);
    end
  endtask

  task automatic test_back_to_back();
    bit wrapped_r = 1'b0;
    bit wrapped_w = 1'b0;
    for (int i = 0; i < 21; i++) cyc(0, 1'b0, 1'b1, 1'b0);  // count 31 -> 10
    for (int i = 0; i < 40; i++) begin
      cyc(0, 1'b1, 1'b1, 1'b0);
      if (read_ptr_v[0] == 5'd0) wrapped_r = 1'b1;
      if (waddr_v[0]    == 5'd0) wrapped_w = 1'b1;
      checks++;
      if (count_v[0] !== 6'd10 ||
          int'(waddr_v[0]) !== (int'(read_ptr_v[0]) + int'(count_v[0])) % 32) begin
        failures++;
        $display("FAIL steady_invariant: got cnt=%0d rp=%0d wp=%0d expected cnt=10 wp=(rp+cnt)%%32",
                 count_v[0], read_ptr_v[0], waddr_v[0]);
      end
    end
    checks++;
    if (!(wrapped_r && wrapped_w)) begin
      failures++;
      $display("FAIL steady_wrap: got rp_wrap=%b wp_wrap=%b expected 1/1", wrapped_r, wrapped_w);
    end
  endtask

  task automatic test_clr();
    for (int i = 0; i < 3; i++) cyc(0, 1'b0, 1'b1, 1'b0);  // count 10 -> 7
    cyc(0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (count_v[0] !== 6'd0 || read_ptr_v[0] !== 5'd0 || waddr_v[0] !== 5'd0 || empty[0] !== 1'b1) begin
      failures++;
      $display("FAIL clr: got cnt=%0d rp=%0d wp=%0d empty=%b expected 0/0/0/1",
               count_v[0], read_ptr_v[0], waddr_v[0], empty[0]);
    end
    for (int i = 0; i < 3; i++) cyc(0, 1'b1, 1'b0, 1'b0);
    cyc(0, 1'b0, 1'b1, 1'b0);  // pop refused at count 3
    checks++;
    if (count_v[0] !== 6'd3 || read_ptr_v[0] !== 5'd0) begin
      failures++;
      $display("FAIL underflow_pop: got cnt=%0d rp=%0d expected 3/0", count_v[0], read_ptr_v[0]);
    end
`ifdef BUF_PTR_ERR_FLAGS_EN
    checks++;
    if (unf_v[0] !== 1'b1 || ovf_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL unf_err: got unf=%b ovf=%b expected 1/0", unf_v[0], ovf_v[0]);
    end
`endif
  endtask

  task automatic test_wrap24();
    for (int i = 0; i < 24; i++) cyc(1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)  cyc(1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (read_ptr_v[1] !== 5'd20 || count_v[1] !== 6'd4) begin
      failures++;
      $display("FAIL wrap24_setup: got rp=%0d cnt=%0d expected 20/4", read_ptr_v[1], count_v[1]);
    end
    cyc(1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (read_ptr_v[1] !== 5'd0) begin
      failures++;
      $display("FAIL wrap24_20to0: got %0d expected 0", read_ptr_v[1]);
    end
    for (int k = 1; k <= 6; k++) begin
      for (int i = 0; i < 4; i++) cyc(1, 1'b1, 1'b0, 1'b0);
      cyc(1, 1'b0, 1'b1, 1'b0);
      checks++;
      if (int'(read_ptr_v[1]) !== (4 * k) % 24) begin
        failures++;
        $display("FAIL wrap24_step%0d: got %0d expected %0d", k, read_ptr_v[1], (4 * k) % 24);
      end
    end
  endtask

  initial begin
    rst = 2'b11; clr = 2'b00; wen = 2'b00; ren = 2'b00;
    test_reset();
    test_write();
    test_fill();
    test_full_wr_pop();
    test_back_to_back();
    test_clr();
    test_wrap24();
    @(negedge clk);
    wen = 2'b00; ren = 2'b00; clr = 2'b00;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/buffer_ptr_ctrl.md
Name: buffer_ptr_ctrl

Overview:
Pointer/occupancy controller for the column circular buffer. Sits directly upstream of the parallel read-address generator. It owns write_ptr, read_ptr and the occupancy count. It accepts single-column writes, signals when PAR_READ consecutive columns are readable, and advances read_ptr by STRIDE on each accepted pop, wrapping modulo COLUMNS. The read_ptr output drives the address generator, which expands it into PAR_READ wrapped read addresses.

Parameters:
COLUMNS, 32, number of buffer columns; any value >= PAR_READ, power of 2 not required
PAR_READ, 4, columns read in parallel per pop; 1..COLUMNS
STRIDE, 1, columns released per accepted pop; 1..PAR_READ

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
clr  in  1  synchronous flush: empties buffer and zeroes pointers
wen  in  1  write request for one column
ren  in  1  pop request: consume STRIDE columns
waddr  out  $clog2(COLUMNS)  column address for the current write (equals write_ptr)
we_acc  out  1  write accepted this cycle (wen && !full); drives buffer write enable
read_ptr  out  $clog2(COLUMNS)  base read column, fed to address generator
rd_valid  out  1  count >= PAR_READ
pop_acc  out  1  ren && rd_valid
full  out  1  count == COLUMNS
empty  out  1  count == 0
count  out  $clog2(COLUMNS)+1  current occupancy

Behaviour:
- Reset and clr (rst has priority; clr is identical in effect): write_ptr=0, read_ptr=0, count=0. Consequently empty=1, full=0, rd_valid=0, we_acc=0, pop_acc=0. When clr is active in a cycle, wen and ren in that cycle are ignored.
- State: write_ptr, read_ptr and count registers only. full, empty, rd_valid, waddr and read_ptr are decoded from registers, with no combinational path from the inputs. we_acc and pop_acc are combinational from wen/ren and the registered state.
- Write: when we_acc=1, write_ptr <= (write_ptr==COLUMNS-1) ? 0 : write_ptr+1. The data write goes to waddr in the same cycle.
- Pop: when pop_acc=1, read_ptr <= read_ptr+STRIDE, minus COLUMNS if the sum is >= COLUMNS. Compute the sum at $clog2(COLUMNS)+1 bits so it cannot overflow.
- count_next = count + we_acc - (pop_acc ? STRIDE : 0), computed at count width. It never underflows, because pop requires count >= PAR_READ >= STRIDE.
- Simultaneous write and pop: both take effect. Write acceptance depends only on the registered full, so a write is refused while full even if a pop occurs in the same cycle. This means no bypass.
- Latency: an accepted write is reflected in count, rd_valid and full on the next edge. A pop updates read_ptr on the next edge.
- Refused requests (wen while full, ren while !rd_valid) are dropped silently and change no state.
- Invariant: write_ptr == (read_ptr + count) mod COLUMNS, always.
- Wrap-around: both pointers wrap independently, and non-power-of-2 COLUMNS must wrap correctly (for example COLUMNS=24: 23 -> 0; read_ptr 22 + STRIDE 4 -> 2).

Optional Feature:
Macro BUF_PTR_ERR_FLAGS_EN.
- Defined: adds outputs ovf_err (1) and unf_err (1). These are sticky flags:
  - ovf_err sets on wen && full.
  - unf_err sets on ren && !rd_valid.
  - Both are cleared only by rst or clr. A flag is visible the cycle after the offending request.
- Undefined: these ports do not exist, and refused requests leave no trace.

Test Plan:
- Reset then 4 writes (COLUMNS=32, PAR_READ=4, STRIDE=1) -> waddr 0,1,2,3 with we_acc=1; after the 4th edge count=4 and rd_valid=1; read_ptr=0.
- Fill 32 writes, then a 33rd wen -> full=1, we_acc=0, count stays 32, write_ptr=0; with BUF_PTR_ERR_FLAGS_EN, ovf_err=1 next cycle.
- Full buffer, assert wen and ren together -> pop accepted, write refused; count 32 -> 31, read_ptr 0 -> 1.
- count=10, wen and ren together each cycle for 40 cycles -> count remains 10; read_ptr and write_ptr wrap past 31 -> 0 and keep the invariant every cycle.
- COLUMNS=24, STRIDE=4, read_ptr driven to 20 by writes and pops -> next pop gives read_ptr=0; then read_ptr 0, 4, ..., 20, 0.
- Mid-stream clr with wen=ren=1 at count=7 -> next cycle count=0, both pointers 0, empty=1; the simultaneous write and pop are discarded. Also with count=3 and ren=1 -> pop_acc=0, no change, and unf_err=1 when the macro is enabled.
